instr_fetch_64: RTL

// Fetch stage of the multicycle 64-bit core. Holds the fetch PC and runs one
// req/ack transaction per fetch_start against instruction memory. Drives the

---
 rtl/core_pkg.sv | 25 ++
 rtl/instr_fetch_64.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the multicycle 64-bit core: widths and fetch-stage state/fault encodings.
package core_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    FS_IDLE      = 3'd0,
    FS_REQ       = 3'd1,
    FS_WAIT_KILL = 3'd2,
    FS_DONE      = 3'd3,
    FS_FAULT     = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    FF_NONE     = 2'd0,
    FF_MISALIGN = 2'd1,
    FF_TIMEOUT  = 2'd2
  } fetch_fault_t;

  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_64.sv
// Fetch stage: owns the fetch PC and runs one imem req/ack transaction per fetch_start,
// with redirect, kill-on-redirect, misalignment and timeout handling.
module instr_fetch_64
  import core_pkg::*;
#(
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_start,
  input  logic         redirect_valid,
  input  logic [63:0]  redirect_target,
  output logic         imem_req,
  output logic [63:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic         load_ir,
  output logic [31:0]  instruction,
  output logic [63:0]  pc,
  output logic         fetch_busy,
  output logic         fault,
  output logic [1:0]   fault_cause,
  output fetch_state_t dbg_state
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Memory handshake: imem_req stays high with imem_addr frozen until imem_ack is
  // sampled on a rising edge; acks arriving while imem_req is low are ignored.
  fetch_state_t state_q, state_d;
  logic [63:0]  fetch_pc_q, fetch_pc_d;
  logic [63:0]  addr_q, addr_d;
  logic [63:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         req_q, req_d;
  logic         load_ir_q, load_ir_d;
  logic         busy_q, busy_d;
  logic         fault_q, fault_d;
  fetch_fault_t cause_q, cause_d;
  logic         kill_q, kill_d;
  logic [7:0]   timer_q, timer_d;
  logic [63:0]  wk_target;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    req_d      = req_q;
    load_ir_d  = 1'b0;
    fault_d    = fault_q;
    cause_d    = cause_q;
    kill_d     = kill_q;
    timer_d    = timer_q;
    wk_target  = redirect_valid ? redirect_target : fetch_pc_q;

    case (state_q)
      FS_IDLE: begin
        if (redirect_valid) fetch_pc_d = redirect_target;
        if (fetch_start) begin
          if (is_aligned(fetch_pc_q)) begin
            state_d = FS_REQ;
            req_d   = 1'b1;
            addr_d  = fetch_pc_q;
            timer_d = 8'd0;
          end else begin
            state_d = FS_FAULT;
            fault_d = 1'b1;
            cause_d = FF_MISALIGN;
          end
        end
      end
      FS_REQ: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          pc_d       = fetch_pc_q;
          fetch_pc_d = redirect_valid ? redirect_target : fetch_pc_q + 64'(INSTR_BYTES);
          req_d      = 1'b0;
          state_d    = FS_DONE;
        end else if (timer_q == TIMER_LAST) begin
          req_d   = 1'b0;
          fault_d = 1'b1;
          cause_d = FF_TIMEOUT;
          state_d = FS_FAULT;
        end else begin
          timer_d = timer_q + 8'd1;
          if (redirect_valid) begin
            fetch_pc_d = redirect_target;
            kill_d     = 1'b1;
            state_d    = FS_WAIT_KILL;
          end
        end
      end
      FS_WAIT_KILL: begin
        // The in-flight word belongs to the squashed path; drain it, then chase the target.
        fetch_pc_d = wk_target;
        if (imem_ack) begin
          kill_d = 1'b0;
          if (is_aligned(wk_target)) begin
            state_d = FS_REQ;
            req_d   = 1'b1;
            addr_d  = wk_target;
            timer_d = 8'd0;
          end else begin
            req_d   = 1'b0;
            fault_d = 1'b1;
            cause_d = FF_MISALIGN;
            state_d = FS_FAULT;
          end
        end else if (timer_q == TIMER_LAST) begin
          req_d   = 1'b0;
          kill_d  = 1'b0;
          fault_d = 1'b1;
          cause_d = FF_TIMEOUT;
          state_d = FS_FAULT;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      FS_DONE: begin
        load_ir_d = 1'b1;
        state_d   = FS_IDLE;
        if (redirect_valid) fetch_pc_d = redirect_target;
      end
      FS_FAULT: begin
        if (redirect_valid && is_aligned(redirect_target)) begin
          fault_d    = 1'b0;
          cause_d    = FF_NONE;
          fetch_pc_d = redirect_target;
          state_d    = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    busy_d = (state_d == FS_REQ) || (state_d == FS_WAIT_KILL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      req_q      <= 1'b0;
      load_ir_q  <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= FF_NONE;
      kill_q     <= 1'b0;
      timer_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      req_q      <= req_d;
      load_ir_q  <= load_ir_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      kill_q     <= kill_d;
      timer_q    <= timer_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign load_ir     = load_ir_q;
  assign instruction = instr_q;
  assign pc          = pc_q;
  assign fetch_busy  = busy_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign dbg_state   = state_q;

endmodule
